// File: rtl/sd_cmd_engine.sv
// SD CMD-line transaction engine: frames and shifts out a 48-bit command with CRC7 and
// optionally receives and checks a 48-bit response. All line activity advances on bit_tick.
module sd_cmd_engine #(
   parameter int unsigned PRE_BITS     = 8,
   parameter int unsigned RESP_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bit_tick,
   input  logic        start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic        expect_resp,
   output logic        busy,
   output logic        done,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg,
   output logic        resp_crc_err,
   output logic        timeout,
   output logic        sd_cmd_out,
   output logic        sd_cmd_oe,
   input  logic        sd_cmd_in
);

   localparam int unsigned PW = $clog2(PRE_BITS + 1);
   localparam int unsigned WW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

   typedef enum logic [2:0] {StIdle, StPre, StSend, StWait, StRecv, StFin} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [5:0]    bit_q, bit_d;
   logic [39:0]   tx_q, tx_d;
   logic [45:0]   rx_q, rx_d;
   logic [6:0]    crc_q, crc_d;
   logic          exp_q, exp_d;
   logic          out_q, out_d;
   logic [5:0]    resp_index_q, resp_index_d;
   logic [31:0]   resp_arg_q, resp_arg_d;
   logic          err_q, err_d;
   logic          tmo_q, tmo_d;

   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   assign busy         = (state_q == StPre) || (state_q == StSend) ||
                         (state_q == StWait) || (state_q == StRecv);
   assign done         = (state_q == StFin);
   assign sd_cmd_oe    = (state_q == StPre) || (state_q == StSend);
   assign sd_cmd_out   = out_q;
   assign resp_index   = resp_index_q;
   assign resp_arg     = resp_arg_q;
   assign resp_crc_err = err_q;
   assign timeout      = tmo_q;

   always_comb begin
      state_d      = state_q;
      pre_d        = pre_q;
      wait_d       = wait_q;
      bit_d        = bit_q;
      tx_d         = tx_q;
      rx_d         = rx_q;
      crc_d        = crc_q;
      exp_d        = exp_q;
      out_d        = out_q;
      resp_index_d = resp_index_q;
      resp_arg_d   = resp_arg_q;
      err_d        = err_q;
      tmo_d        = tmo_q;

      unique case (state_q)
         StIdle: ;
         StFin:  state_d = StIdle;
         StPre: begin
            if (bit_tick) begin
               if (pre_q == PW'(PRE_BITS)) begin
                  // This tick closes the last preamble period and opens the start bit.
                  state_d = StSend;
                  out_d   = tx_q[39];
                  crc_d   = crc7_step(7'h00, tx_q[39]);
                  tx_d    = {tx_q[38:0], 1'b0};
                  bit_d   = 6'd47;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
         end
         StSend: begin
            if (bit_tick) begin
               if (bit_q == 6'd0) begin
                  out_d   = 1'b1;
                  wait_d  = '0;
                  state_d = exp_q ? StWait : StFin;
               end else begin
                  bit_d = bit_q - 6'd1;
                  if (bit_q > 6'd8) begin
                     out_d = tx_q[39];
                     crc_d = crc7_step(crc_q, tx_q[39]);
                     tx_d  = {tx_q[38:0], 1'b0};
                  end else if (bit_q > 6'd1) begin
                     out_d = crc_q[6];
                     crc_d = {crc_q[5:0], 1'b0};
                  end else begin
                     out_d = 1'b1;
                  end
               end
            end
         end
         StWait: begin
            if (bit_tick) begin
               if (!sd_cmd_in) begin
                  // Start bit is zero, so the CRC state after it is still zero.
                  state_d = StRecv;
                  bit_d   = 6'd46;
                  crc_d   = 7'h00;
                  rx_d    = '0;
               end else if (wait_q == WW'(RESP_TIMEOUT - 1)) begin
                  tmo_d   = 1'b1;
                  state_d = StFin;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
         end
         StRecv: begin
            if (bit_tick) begin
               rx_d = {rx_q[44:0], sd_cmd_in};
               if (bit_q >= 6'd8) crc_d = crc7_step(crc_q, sd_cmd_in);
               if (bit_q == 6'd0) begin
                  // rx_q now holds response bits 46..1.
                  err_d        = (crc_q != rx_q[6:0]) | ~sd_cmd_in | rx_q[45];
                  resp_index_d = rx_q[44:39];
                  resp_arg_d   = rx_q[38:7];
                  state_d      = StFin;
               end else begin
                  bit_d = bit_q - 6'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (start && !busy) begin
         state_d      = StPre;
         pre_d        = '0;
         tx_d         = {2'b01, cmd_index, cmd_arg};
         exp_d        = expect_resp;
         out_d        = 1'b1;
         resp_index_d = '0;
         resp_arg_d   = '0;
         err_d        = 1'b0;
         tmo_d        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         pre_q        <= '0;
         wait_q       <= '0;
         bit_q        <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         crc_q        <= '0;
         exp_q        <= 1'b0;
         out_q        <= 1'b1;
         resp_index_q <= '0;
         resp_arg_q   <= '0;
         err_q        <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_q        <= pre_d;
         wait_q       <= wait_d;
         bit_q        <= bit_d;
         tx_q         <= tx_d;
         rx_q         <= rx_d;
         crc_q        <= crc_d;
         exp_q        <= exp_d;
         out_q        <= out_d;
         resp_index_q <= resp_index_d;
         resp_arg_q   <= resp_arg_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
      end
   end

endmodule
